// File: rtl/mc_control_pkg.sv
// Shared encodings for the MIPS-lite multi-cycle controller: opcodes, functs,
// datapath select codes, FSM state codes and the decoder's output records.
package mc_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  localparam logic [2:0] REGDST_RT = 3'd0;
  localparam logic [2:0] REGDST_RD = 3'd1;
  localparam logic [2:0] REGDST_RA = 3'd2;

  localparam logic [2:0] ALUSRC_RD2 = 3'd0;
  localparam logic [2:0] ALUSRC_EXT = 3'd1;

  localparam logic [2:0] TOREG_ALU = 3'd0;
  localparam logic [2:0] TOREG_MEM = 3'd1;
  localparam logic [2:0] TOREG_EXT = 3'd2;
  localparam logic [2:0] TOREG_PC4 = 3'd3;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_BEQ = 3'd1;
  localparam logic [2:0] NPC_JAL = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [3:0] ALU_NONE = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd3;

  localparam logic [2:0] EXT_ZERO = 3'd0;
  localparam logic [2:0] EXT_SIGN = 3'd1;
  localparam logic [2:0] EXT_LUI  = 3'd2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef struct packed {
    logic addu;
    logic subu;
    logic ori;
    logic lui;
    logic lw;
    logic sw;
    logic beq;
    logic jal;
    logic jr;
    logic unknown;
  } instr_t;

  typedef struct packed {
    logic [2:0] regDst;
    logic [2:0] aluSrc;
    logic [2:0] toReg;
    logic [3:0] aluOp;
    logic [2:0] extOp;
  } sel_t;

  function automatic logic isMemOp(input instr_t i);
    return i.lw | i.sw;
  endfunction

  function automatic logic isAluOp(input instr_t i);
    return i.addu | i.subu | i.ori | i.lui;
  endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Combinational instruction decoder: Op/Func to instruction one-hots plus the
// per-instruction datapath selects, which the FSM then gates by state.
module mc_decode
  import mc_control_pkg::*;
(
  input  logic [5:0] i_op,
  input  logic [5:0] i_func,
  output instr_t     o_instr,
  output sel_t       o_sel
);

  logic w_rType;

  assign w_rType = (i_op == OP_RTYPE);

  // Anything that matches no supported encoding falls through to a nop.
  always_comb begin
    o_instr = '0;
    o_instr.addu = w_rType && (i_func == FN_ADDU);
    o_instr.subu = w_rType && (i_func == FN_SUBU);
    o_instr.jr   = w_rType && (i_func == FN_JR);
    o_instr.ori  = (i_op == OP_ORI);
    o_instr.lui  = (i_op == OP_LUI);
    o_instr.lw   = (i_op == OP_LW);
    o_instr.sw   = (i_op == OP_SW);
    o_instr.beq  = (i_op == OP_BEQ);
    o_instr.jal  = (i_op == OP_JAL);
    o_instr.unknown = ~(o_instr.addu | o_instr.subu | o_instr.jr | o_instr.ori |
                        o_instr.lui | o_instr.lw | o_instr.sw | o_instr.beq |
                        o_instr.jal);
  end

  always_comb begin
    o_sel = '0;
    if (o_instr.addu) begin
      o_sel.regDst = REGDST_RD;
      o_sel.aluSrc = ALUSRC_RD2;
      o_sel.toReg  = TOREG_ALU;
      o_sel.aluOp  = ALU_ADD;
      o_sel.extOp  = EXT_ZERO;
    end else if (o_instr.subu) begin
      o_sel.regDst = REGDST_RD;
      o_sel.aluSrc = ALUSRC_RD2;
      o_sel.toReg  = TOREG_ALU;
      o_sel.aluOp  = ALU_SUB;
      o_sel.extOp  = EXT_ZERO;
    end else if (o_instr.ori) begin
      o_sel.regDst = REGDST_RT;
      o_sel.aluSrc = ALUSRC_EXT;
      o_sel.toReg  = TOREG_ALU;
      o_sel.aluOp  = ALU_OR;
      o_sel.extOp  = EXT_ZERO;
    end else if (o_instr.lui) begin
      // The upper-immediate comes straight from EXT; the ALU result is unused.
      o_sel.regDst = REGDST_RT;
      o_sel.aluSrc = ALUSRC_EXT;
      o_sel.toReg  = TOREG_EXT;
      o_sel.aluOp  = ALU_NONE;
      o_sel.extOp  = EXT_LUI;
    end else if (o_instr.lw) begin
      o_sel.regDst = REGDST_RT;
      o_sel.aluSrc = ALUSRC_EXT;
      o_sel.toReg  = TOREG_MEM;
      o_sel.aluOp  = ALU_ADD;
      o_sel.extOp  = EXT_SIGN;
    end else if (o_instr.sw) begin
      o_sel.aluSrc = ALUSRC_EXT;
      o_sel.aluOp  = ALU_ADD;
      o_sel.extOp  = EXT_SIGN;
    end else if (o_instr.beq) begin
      o_sel.aluSrc = ALUSRC_RD2;
      o_sel.aluOp  = ALU_SUB;
      o_sel.extOp  = EXT_SIGN;
    end else if (o_instr.jal) begin
      o_sel.regDst = REGDST_RA;
      o_sel.toReg  = TOREG_PC4;
    end
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle Moore controller for the MIPS-lite datapath: FETCH/DECODE/EXEC/MEM/WB
// sequencing, reset gating of every enable, and the retired-instruction counter.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  input  logic             mem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic             MemReq,
  output logic [2:0]       RegDstSel,
  output logic [2:0]       ALUSrcSel,
  output logic [2:0]       toRegSel,
  output logic [2:0]       NPCOp,
  output logic [3:0]       ALUOp,
  output logic [2:0]       EXTOp,
  output logic [2:0]       state,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt
);

  state_e           r_state;
  logic [CNT_W-1:0] r_instrCnt;

  state_e     w_nextState;
  instr_t     w_instr;
  sel_t       w_sel;
  logic       w_irWrite;
  logic       w_pcWrite;
  logic       w_regWrite;
  logic       w_memWrite;
  logic       w_memReq;
  logic [2:0] w_regDst;
  logic [2:0] w_aluSrc;
  logic [2:0] w_toReg;
  logic [2:0] w_npcOp;
  logic [3:0] w_aluOp;
  logic [2:0] w_extOp;

  mc_decode u_decode (
    .i_op    (Op),
    .i_func  (Func),
    .o_instr (w_instr),
    .o_sel   (w_sel)
  );

  // The counter advances on the edge that closes a retiring cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_instrCnt <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_pcWrite) begin
        r_instrCnt <= r_instrCnt + CNT_W'(1);
      end
    end
  end

  // Every instruction ends in a cycle with PCWrite=1, which is also its retire cycle.
  always_comb begin
    w_nextState = r_state;
    w_irWrite   = 1'b0;
    w_pcWrite   = 1'b0;
    w_regWrite  = 1'b0;
    w_memWrite  = 1'b0;
    w_memReq    = 1'b0;
    w_regDst    = REGDST_RT;
    w_aluSrc    = ALUSRC_RD2;
    w_toReg     = TOREG_ALU;
    w_npcOp     = NPC_PC4;
    w_aluOp     = ALU_NONE;
    w_extOp     = EXT_ZERO;

    if (r_state != S_FETCH) begin
      w_aluOp = w_sel.aluOp;
      w_extOp = w_sel.extOp;
    end

    case (r_state)
      S_FETCH: begin
        w_memReq = 1'b1;
        if (mem_ready) begin
          w_irWrite   = 1'b1;
          w_nextState = S_DECODE;
        end
      end

      S_DECODE: begin
        if (w_instr.jal) begin
          w_nextState = S_WB;
        end else if (w_instr.jr) begin
          w_pcWrite   = 1'b1;
          w_npcOp     = NPC_JR;
          w_nextState = S_FETCH;
        end else if (w_instr.unknown) begin
          w_pcWrite   = 1'b1;
          w_npcOp     = NPC_PC4;
          w_nextState = S_FETCH;
        end else begin
          w_nextState = S_EXEC;
        end
      end

      S_EXEC: begin
        w_aluSrc = w_sel.aluSrc;
        if (isMemOp(w_instr)) begin
          w_nextState = S_MEM;
        end else if (w_instr.beq) begin
          w_pcWrite   = 1'b1;
          w_npcOp     = NPC_BEQ;
          w_nextState = S_FETCH;
        end else if (isAluOp(w_instr)) begin
          w_nextState = S_WB;
        end else begin
          w_pcWrite   = 1'b1;
          w_nextState = S_FETCH;
        end
      end

      S_MEM: begin
        // The address is recomputed here, so the ALU source stays on EXT.
        w_memReq = 1'b1;
        w_aluOp  = ALU_ADD;
        w_aluSrc = w_sel.aluSrc;
        if (mem_ready) begin
          if (w_instr.sw) begin
            w_memWrite  = 1'b1;
            w_pcWrite   = 1'b1;
            w_nextState = S_FETCH;
          end else begin
            w_nextState = S_WB;
          end
        end
      end

      S_WB: begin
        w_regWrite  = 1'b1;
        w_regDst    = w_sel.regDst;
        w_toReg     = w_sel.toReg;
        w_pcWrite   = 1'b1;
        w_npcOp     = w_instr.jal ? NPC_JAL : NPC_PC4;
        w_nextState = S_FETCH;
      end

      default: begin
        w_nextState = S_FETCH;
      end
    endcase
  end

  assign IRWrite  = w_irWrite  & ~reset;
  assign PCWrite  = w_pcWrite  & ~reset;
  assign RegWrite = w_regWrite & ~reset;
  assign MemWrite = w_memWrite & ~reset;
  assign MemReq   = w_memReq   & ~reset;
  assign retire   = PCWrite;
  assign NPCOp    = PCWrite ? w_npcOp : NPC_PC4;

  assign RegDstSel = w_regDst;
  assign ALUSrcSel = w_aluSrc;
  assign toRegSel  = w_toReg;
  assign ALUOp     = w_aluOp;
  assign EXTOp     = w_extOp;
  assign state     = r_state;
  assign instr_cnt = r_instrCnt;

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control: stimulus pushes hand-computed per-cycle control
// vectors, a negedge monitor pops and compares them against the DUT outputs.
module tb_mc_control;

  logic       clk;
  logic       reset;
  logic [5:0] Op;
  logic [5:0] Func;
  logic       mem_ready;
  logic       IRWrite, PCWrite, RegWrite, MemWrite, MemReq;
  logic [2:0] RegDstSel, ALUSrcSel, toRegSel, NPCOp, EXTOp, state;
  logic [3:0] ALUOp;
  logic       retire;
  logic [3:0] instr_cnt;

  logic [31:0] expQ[$];
  string       nameQ[$];
  logic [3:0]  expCnt;
  int          vectors;
  int          fails;

  mc_control #(.CNT_W(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .Op        (Op),
    .Func      (Func),
    .mem_ready (mem_ready),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .MemReq    (MemReq),
    .RegDstSel (RegDstSel),
    .ALUSrcSel (ALUSrcSel),
    .toRegSel  (toRegSel),
    .NPCOp     (NPCOp),
    .ALUOp     (ALUOp),
    .EXTOp     (EXTOp),
    .state     (state),
    .retire    (retire),
    .instr_cnt (instr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One call describes one clock cycle: en = {IRWrite,PCWrite,RegWrite,MemWrite,MemReq}.
  task automatic applyStimulus(input string nm, input logic mr, input logic [2:0] st,
                               input logic [4:0] en, input logic [2:0] rd,
                               input logic [2:0] as, input logic [2:0] tr,
                               input logic [2:0] npc, input logic [3:0] alu,
                               input logic [2:0] ext);
    mem_ready = mr;
    expQ.push_back({st, en, rd, as, tr, npc, alu, ext, en[3], expCnt});
    nameQ.push_back(nm);
    if (en[3]) expCnt = expCnt + 4'd1;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string nm, input logic [31:0] expVec);
    logic [31:0] actVec;
    actVec = {state, IRWrite, PCWrite, RegWrite, MemWrite, MemReq, RegDstSel, ALUSrcSel,
              toRegSel, NPCOp, ALUOp, EXTOp, retire, instr_cnt};
    vectors++;
    if (actVec !== expVec) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", nm, actVec, expVec);
    end
  endtask

  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      checkOutput(nameQ.pop_front(), expQ.pop_front());
    end
  end

  task automatic fetchOk(input string nm);
    applyStimulus({nm, "_F"}, 1'b1, 3'd0, 5'b10001, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
  endtask

  initial begin
    vectors   = 0;
    fails     = 0;
    expCnt    = 4'd0;
    reset     = 1'b1;
    mem_ready = 1'b0;
    Op        = 6'h00;
    Func      = 6'h00;
    repeat (2) @(posedge clk);
    #1;
    applyStimulus("rst_idle", 1'b1, 3'd0, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
    reset = 1'b0;

    // lw abandoned by a 3-cycle reset while stalled in MEM
    Op = 6'h23; Func = 6'h00;
    fetchOk("lwR");
    applyStimulus("lwR_D",  1'b1, 3'd1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("lwR_E",  1'b1, 3'd2, 5'b00000, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("lwR_M",  1'b0, 3'd3, 5'b00001, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);
    reset = 1'b1;
    applyStimulus("lwR_R1", 1'b1, 3'd3, 5'b00000, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("lwR_R2", 1'b1, 3'd0, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
    applyStimulus("lwR_R3", 1'b1, 3'd0, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
    reset = 1'b0;

    // addu $3,$1,$2
    Op = 6'h00; Func = 6'h21;
    fetchOk("addu");
    applyStimulus("addu_D", 1'b1, 3'd1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd2, 3'd0);
    applyStimulus("addu_E", 1'b1, 3'd2, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd2, 3'd0);
    applyStimulus("addu_W", 1'b1, 3'd4, 5'b01100, 3'd1, 3'd0, 3'd0, 3'd0, 4'd2, 3'd0);

    // lw with two MEM stall cycles
    Op = 6'h23; Func = 6'h00;
    fetchOk("lw");
    applyStimulus("lw_D",  1'b1, 3'd1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("lw_E",  1'b1, 3'd2, 5'b00000, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("lw_M0", 1'b0, 3'd3, 5'b00001, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("lw_M1", 1'b0, 3'd3, 5'b00001, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("lw_M2", 1'b1, 3'd3, 5'b00001, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("lw_W",  1'b1, 3'd4, 5'b01100, 3'd0, 3'd0, 3'd1, 3'd0, 4'd2, 3'd1);

    // sw with one FETCH stall and one MEM stall
    Op = 6'h2B; Func = 6'h00;
    applyStimulus("sw_F0", 1'b0, 3'd0, 5'b00001, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
    fetchOk("sw");
    applyStimulus("sw_D",  1'b1, 3'd1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("sw_E",  1'b1, 3'd2, 5'b00000, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("sw_M0", 1'b0, 3'd3, 5'b00001, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);
    applyStimulus("sw_M1", 1'b1, 3'd3, 5'b01011, 3'd0, 3'd1, 3'd0, 3'd0, 4'd2, 3'd1);

    // jal then jr (mem_ready low in DECODE must be ignored)
    Op = 6'h03; Func = 6'h00;
    fetchOk("jal");
    applyStimulus("jal_D", 1'b1, 3'd1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd0);
    applyStimulus("jal_W", 1'b0, 3'd4, 5'b01100, 3'd2, 3'd0, 3'd3, 3'd2, 4'd0, 3'd0);
    Op = 6'h00; Func = 6'h08;
    fetchOk("jr");
    applyStimulus("jr_D",  1'b0, 3'd1, 5'b01000, 3'd0, 3'd0, 3'd0, 3'd3, 4'd0, 3'd0);

    // beq
    Op = 6'h04; Func = 6'h00;
    fetchOk("beq");
    applyStimulus("beq_D", 1'b1, 3'd1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd3, 3'd1);
    applyStimulus("beq_E", 1'b1, 3'd2, 5'b01000, 3'd0, 3'd0, 3'd0, 3'd1, 4'd3, 3'd1);

    // ori
    Op = 6'h0D; Func = 6'h00;
    fetchOk("ori");
    applyStimulus("ori_D", 1'b1, 3'd1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd1, 3'd0);
    applyStimulus("ori_E", 1'b1, 3'd2, 5'b00000, 3'd0, 3'd1, 3'd0, 3'd0, 4'd1, 3'd0);
    applyStimulus("ori_W", 1'b1, 3'd4, 5'b01100, 3'd0, 3'd0, 3'd0, 3'd0, 4'd1, 3'd0);

    // lui
    Op = 6'h0F; Func = 6'h00;
    fetchOk("lui");
    applyStimulus("lui_D", 1'b1, 3'd1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd0, 3'd2);
    applyStimulus("lui_E", 1'b1, 3'd2, 5'b00000, 3'd0, 3'd1, 3'd0, 3'd0, 4'd0, 3'd2);
    applyStimulus("lui_W", 1'b1, 3'd4, 5'b01100, 3'd0, 3'd0, 3'd2, 3'd0, 4'd0, 3'd2);

    // subu
    Op = 6'h00; Func = 6'h23;
    fetchOk("subu");
    applyStimulus("subu_D", 1'b1, 3'd1, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd3, 3'd0);
    applyStimulus("subu_E", 1'b1, 3'd2, 5'b00000, 3'd0, 3'd0, 3'd0, 3'd0, 4'd3, 3'd0);
    applyStimulus("subu_W", 1'b1, 3'd4, 5'b01100, 3'd1, 3'd0, 3'd0, 3'd0, 4'd3, 3'd0);

    // nops (unknown R-type funct first, then Op=6'h3F) until instr_cnt wraps past 15
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        Op = 6'h00; Func = 6'h3F;
      end else begin
        Op = 6'h3F; Func = 6'h00;
      end
      fetchOk($sformatf("nop%0d", i));
      applyStimulus($sformatf("nop%0d_D", i), 1'b1, 3'd1, 5'b01000, 3'd0, 3'd0, 3'd0,
                    3'd0, 4'd0, 3'd0);
    end
    fetchOk("post_wrap");

    if (expQ.size() != 0) begin
      fails++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
